// File: rtl/mem_cache_controller.sv
// mem_cache_controller: 2-way set-associative write-through read cache in front of the SRAM controller
module mem_cache_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] addr,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);
    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
    state_t state, state_next;
    logic [63:0] valid0, valid1, lru;
    logic [9:0]  tag_mem  [2][64];
    logic [31:0] data_mem [2][64];
    logic [5:0]  idx;
    logic [9:0]  tg;
    logic [31:0] hit_data;
    logic        hit0, hit1, hit, hit_way, victim;
    logic        fill, wr_hit, rd_hit;

    assign idx        = addr[7:2];
    assign tg         = addr[17:8];
    assign hit0       = valid0[idx] && tag_mem[0][idx] == tg;
    assign hit1       = valid1[idx] && tag_mem[1][idx] == tg;
    assign hit        = hit0 || hit1;
    assign hit_way    = hit1;
    assign hit_data   = hit1 ? data_mem[1][idx] : data_mem[0][idx];
    assign victim     = !valid0[idx] ? 1'b0 : !valid1[idx] ? 1'b1 : lru[idx];
    assign sram_addr  = addr;
    assign sram_wdata = wdata;

    // State register; reset drops any in-flight SRAM request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, pipeline handshake and SRAM requests; reset forces the idle output pattern
    always_comb begin
        state_next = state;
        ready      = 1'b1;
        rdata      = '0;
        sram_r_en  = 1'b0;
        sram_w_en  = 1'b0;
        fill       = 1'b0;
        wr_hit     = 1'b0;
        rd_hit     = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_W_EN) begin
                    ready      = 1'b0;
                    state_next = WR_THRU;
                end else if (MEM_R_EN) begin
                    ready      = hit;
                    rdata      = hit ? hit_data : '0;
                    rd_hit     = hit;
                    state_next = hit ? IDLE : RD_MISS;
                end
            end
            RD_MISS: begin
                sram_r_en  = 1'b1;
                ready      = sram_ready;
                rdata      = sram_ready ? sram_rdata : '0;
                fill       = sram_ready;
                state_next = sram_ready ? IDLE : RD_MISS;
            end
            WR_THRU: begin
                sram_w_en  = 1'b1;
                ready      = sram_ready;
                wr_hit     = sram_ready && hit;
                state_next = sram_ready ? IDLE : WR_THRU;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            ready     = 1'b1;
            rdata     = '0;
            sram_r_en = 1'b0;
            sram_w_en = 1'b0;
            fill      = 1'b0;
            wr_hit    = 1'b0;
            rd_hit    = 1'b0;
        end
    end

    // Valid bits and LRU: set on fill, LRU points away from the most recently touched way
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else if (fill) begin
            if (victim) valid1[idx] <= 1'b1;
            else        valid0[idx] <= 1'b1;
            lru[idx] <= ~victim;
        end else if (rd_hit || wr_hit) begin
            lru[idx] <= ~hit_way;
        end
    end

    // Tag/data arrays are not reset; valid bits guard their contents
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[victim][idx]  <= tg;
            data_mem[victim][idx] <= sram_rdata;
        end else if (wr_hit) begin
            data_mem[hit_way][idx] <= wdata;
        end
    end
endmodule

// File: tb/tb_mem_cache_controller.sv
// tb_mem_cache_controller: directed and random checks of the cache against a behavioural model
module tb_mem_cache_controller;
    logic        clk = 0, rst = 1;
    logic [17:0] addr = '0;
    logic [31:0] wdata = '0, sram_rdata = '0;
    logic        MEM_R_EN = 0, MEM_W_EN = 0, sram_ready = 0;
    logic [31:0] rdata, sram_wdata;
    logic [17:0] sram_addr;
    logic        ready, sram_r_en, sram_w_en;
    int checks = 0, passed = 0;

    logic        mv [2][64];
    logic [9:0]  mt [2][64];
    logic [31:0] md [2][64];
    logic        ml [64];
    logic [31:0] sram_mem [int];

    mem_cache_controller dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_r_en(sram_r_en),
        .sram_w_en(sram_w_en), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int s = 0; s < 64; s++) begin
            mv[0][s] = 0;
            mv[1][s] = 0;
            ml[s] = 0;
        end
    endfunction

    function automatic int model_way(input logic [17:0] a);
        for (int w = 0; w < 2; w++)
            if (mv[w][a[7:2]] && mt[w][a[7:2]] == a[17:8]) return w;
        return -1;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [17:0] a);
        if (!sram_mem.exists(int'(a[17:2]))) sram_mem[int'(a[17:2])] = $urandom;
        return sram_mem[int'(a[17:2])];
    endfunction

    task automatic do_load(input logic [17:0] a);
        int w = model_way(a);
        int lat = $urandom_range(0, 3);
        int s = int'(a[7:2]);
        int v;
        logic [31:0] d;
        addr = a; MEM_R_EN = 1; MEM_W_EN = 0;
        @(negedge clk);
        if (w >= 0) begin
            checks++;
            if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b1, md[w][s], 2'b00})
                $display("FAIL load_hit addr=%h got ready=%b rdata=%h r_en=%b w_en=%b want ready=1 rdata=%h no request", a, ready, rdata, sram_r_en, sram_w_en, md[w][s]);
            else passed++;
            @(posedge clk); #1;
            ml[s] = (w == 0);
            MEM_R_EN = 0;
        end else begin
            checks++;
            if ({ready, sram_r_en, sram_w_en} !== 3'b000)
                $display("FAIL load_miss_req addr=%h got ready=%b r_en=%b w_en=%b want 000", a, ready, sram_r_en, sram_w_en);
            else passed++;
            @(posedge clk); #1;
            repeat (lat) begin
                @(negedge clk);
                checks++;
                if ({ready, sram_r_en, sram_w_en, sram_addr} !== {3'b010, a})
                    $display("FAIL load_wait addr=%h got ready=%b r_en=%b w_en=%b sram_addr=%h want 0 1 0 %h", a, ready, sram_r_en, sram_w_en, sram_addr, a);
                else passed++;
                @(posedge clk); #1;
            end
            d = mem_rd(a);
            sram_rdata = d; sram_ready = 1;
            @(negedge clk);
            checks++;
            if ({ready, rdata, sram_r_en, sram_w_en, sram_addr} !== {1'b1, d, 2'b10, a})
                $display("FAIL load_fill addr=%h got ready=%b rdata=%h r_en=%b w_en=%b want ready=1 rdata=%h r_en=1", a, ready, rdata, sram_r_en, sram_w_en, d);
            else passed++;
            @(posedge clk); #1;
            sram_ready = 0; MEM_R_EN = 0; sram_rdata = $urandom;
            v = !mv[0][s] ? 0 : !mv[1][s] ? 1 : int'(ml[s]);
            mv[v][s] = 1; mt[v][s] = a[17:8]; md[v][s] = d;
            ml[s] = (v == 0);
        end
    endtask

    task automatic do_store(input logic [17:0] a, input logic [31:0] d, input logic both);
        int w = model_way(a);
        int lat = $urandom_range(0, 3);
        int s = int'(a[7:2]);
        addr = a; wdata = d; MEM_W_EN = 1; MEM_R_EN = both;
        @(negedge clk);
        checks++;
        if ({ready, sram_r_en, sram_w_en} !== 3'b000)
            $display("FAIL store_req addr=%h got ready=%b r_en=%b w_en=%b want 000", a, ready, sram_r_en, sram_w_en);
        else passed++;
        @(posedge clk); #1;
        repeat (lat) begin
            @(negedge clk);
            checks++;
            if ({ready, sram_r_en, sram_w_en, sram_addr, sram_wdata} !== {3'b001, a, d})
                $display("FAIL store_wait addr=%h got ready=%b r_en=%b w_en=%b sram_addr=%h sram_wdata=%h want 0 0 1 %h %h", a, ready, sram_r_en, sram_w_en, sram_addr, sram_wdata, a, d);
            else passed++;
            @(posedge clk); #1;
        end
        sram_ready = 1;
        @(negedge clk);
        checks++;
        if ({ready, sram_r_en, sram_w_en, sram_wdata} !== {3'b101, d})
            $display("FAIL store_done addr=%h got ready=%b r_en=%b w_en=%b sram_wdata=%h want 1 0 1 %h", a, ready, sram_r_en, sram_w_en, sram_wdata, d);
        else passed++;
        @(posedge clk); #1;
        sram_ready = 0; MEM_W_EN = 0; MEM_R_EN = 0;
        sram_mem[int'(a[17:2])] = d;
        if (w >= 0) begin
            md[w][s] = d;
            ml[s] = (w == 0);
        end
    endtask

    task automatic test_reset();
        addr = 18'h00104; MEM_R_EN = 1;
        #12;
        checks++;
        if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b1, 32'h0, 2'b00})
            $display("FAIL reset_outputs got ready=%b rdata=%h r_en=%b w_en=%b want 1 0 0 0", ready, rdata, sram_r_en, sram_w_en);
        else passed++;
        MEM_R_EN = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_cold_read();
        sram_mem[int'(18'h00104 >> 2)] = 32'hDEADBEEF;
        do_load(18'h00104);
        do_load(18'h00104);
    endtask

    task automatic test_replacement();
        do_load(18'h00204);
        do_load(18'h00104);
        do_load(18'h00304);
        do_load(18'h00104);
        do_load(18'h00204);
    endtask

    task automatic test_write_hit();
        do_load(18'h00104);
        do_store(18'h00104, 32'h12345678, 0);
        do_load(18'h00104);
    endtask

    task automatic test_write_miss();
        do_store(18'h00404, 32'hCAFEF00D, 0);
        do_load(18'h00404);
    endtask

    task automatic test_reset_mid_miss();
        do_load(18'h00104);
        addr = 18'h00504; MEM_R_EN = 1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({ready, sram_r_en} !== 2'b01)
            $display("FAIL mid_miss_pre got ready=%b r_en=%b want 0 1", ready, sram_r_en);
        else passed++;
        #2 rst = 1;
        #1;
        checks++;
        if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b1, 32'h0, 2'b00})
            $display("FAIL reset_async got ready=%b rdata=%h r_en=%b w_en=%b want 1 0 0 0", ready, rdata, sram_r_en, sram_w_en);
        else passed++;
        @(negedge clk); #2;
        rst = 0; MEM_R_EN = 0;
        model_reset();
        @(posedge clk); #1;
        do_load(18'h00104);
    endtask

    task automatic test_idle_dual();
        repeat (20) begin
            sram_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b1, 32'h0, 2'b00})
                $display("FAIL idle got ready=%b rdata=%h r_en=%b w_en=%b want 1 0 0 0", ready, rdata, sram_r_en, sram_w_en);
            else passed++;
            @(posedge clk); #1;
        end
        sram_ready = 0;
        do_store(18'h00104, 32'hA5A5_0001, 1);
        do_load(18'h00104);
    endtask

    task automatic test_random();
        logic [17:0] a;
        int op;
        repeat (300) begin
            a = {10'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 9);
            if (op < 6)      do_load(a);
            else if (op < 9) do_store(a, $urandom, 0);
            else             do_store(a, $urandom, 1);
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_replacement();
        test_write_hit();
        test_write_miss();
        test_reset_mid_miss();
        test_idle_dual();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mem_cache_controller.md
# mem_cache_controller

Two-way set-associative, write-through, no-write-allocate read cache between the MEM stage and the SRAM controller. It serves pipeline loads from on-chip tag/data arrays and only starts an SRAM access on a read miss or on any store. It drives `ready` low to freeze the pipeline while an SRAM access is in flight. Each line holds one 32-bit word; there are 64 sets with 1-bit LRU per set.

## Interface
- No parameters. Geometry is fixed: 64 sets, 2 ways, 10-bit tag, 1 word per line.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addr` in 18: byte address (`ALU_result[17:0]`); `[1:0]` ignored, index = `[7:2]`, tag = `[17:8]`.
- `wdata` in 32: store value.
- `MEM_R_EN` in 1: load request, level, held until `ready`.
- `MEM_W_EN` in 1: store request, level, held until `ready`.
- `rdata` out 32: load result, valid when `ready` and `MEM_R_EN`.
- `ready` out 1: low means stall the pipeline.
- `sram_addr` out 18: address to the SRAM controller (`addr` passed through).
- `sram_wdata` out 32: store data to the SRAM controller (`wdata` passed through).
- `sram_r_en` out 1: SRAM read request.
- `sram_w_en` out 1: SRAM write request.
- `sram_rdata` in 32: SRAM read data, valid when `sram_ready` is high.
- `sram_ready` in 1: SRAM controller completion strobe for the asserted request.

## Operation
- **Storage:** per set, per way: valid bit, 10-bit tag, 32-bit data. Per set: `lru` bit, which names the way to replace next.
- **Hit:** `hit_w` = valid[w] && tag[w] == `addr[17:8]`. At most one way hits; a double hit is impossible by construction.
- **States:** IDLE, RD_MISS, WR_THRU.
- **IDLE, no request:** `ready`=1, `rdata`=0, no SRAM request.
- **IDLE, `MEM_R_EN`, hit:** `ready`=1 and `rdata`=hit-way data, combinationally in the same cycle. At the clock edge, `lru`=~hit way. Stay in IDLE.
- **IDLE, `MEM_R_EN`, miss:** `ready`=0. Go to RD_MISS.
- **IDLE, `MEM_W_EN`:** `ready`=0. Go to WR_THRU.
- **Both enables high:** treated as a store. `MEM_R_EN` is ignored.
- **RD_MISS:** `sram_r_en`=1, held. `ready`=`sram_ready`. While `sram_ready`=1, `rdata`=`sram_rdata`. At the edge where `sram_ready`=1:
  - Fill the victim way with valid=1, tag, data.
  - Set `lru`=~victim.
  - Go to IDLE.
- **Victim selection:** way0 if invalid; else way1 if invalid; else the `lru` way.
- **WR_THRU:** `sram_w_en`=1, held. `ready`=`sram_ready`. At the edge where `sram_ready`=1:
  - If the address hits, overwrite that way's data and set `lru`=~hit way.
  - On a miss, no allocation; cache state is unchanged.
  - Go to IDLE.
- **Request gating:** `sram_r_en` and `sram_w_en` are never high together and are never high in IDLE. `sram_addr`/`sram_wdata` follow `addr`/`wdata` at all times. The pipeline holds them stable during a stall.
- **Reset:** asynchronous, active-high. Takes effect at any time, including mid-miss or mid-write; the in-flight SRAM request is dropped.
  - State=IDLE; all valid bits=0; all `lru`=0.
  - Data and tag arrays are not reset.
  - Outputs in reset: `ready`=1, `rdata`=0, `sram_r_en`=0, `sram_w_en`=0.

## Timing
- **Read hit:** 0 stall cycles; result in the request cycle.
- **Read miss:** `ready` low from the request cycle until the cycle `sram_ready`=1. Total latency is 1 + the SRAM controller's latency. The line is written at the end of the completion cycle.
- **Store:** always stalls until SRAM completion, regardless of hit or miss.
- **Back-to-back requests:** the cycle after completion, the FSM is in IDLE and evaluates the next pipeline request. If the same load is re-presented, it now hits.
- **`sram_ready` outside RD_MISS/WR_THRU:** ignored.
- **Arrays:** read combinationally, written only on rising `clk`.

## Test plan
- **Cold read then re-read:** after reset, load 0x00104 (set 1, tag 1).
  - Expect `sram_r_en`=1 with `sram_addr`=0x00104 and `ready`=0 until `sram_ready` pulses with 0xDEADBEEF.
  - On that cycle, `rdata`=0xDEADBEEF and `ready`=1.
  - Re-load 0x00104: `ready`=1 the same cycle, `rdata`=0xDEADBEEF, `sram_r_en` stays 0.
- **Replacement:** load 0x00104, then 0x00204 (fills way1), then re-load 0x00104 (hit, `lru`→1).
  - Load 0x00304: way1 is evicted.
  - 0x00104 still hits; 0x00204 misses with `sram_r_en`=1.
- **Write hit:** with 0x00104 cached, store 0x12345678.
  - Expect `sram_w_en`=1 with `sram_wdata`=0x12345678 and `ready`=0 until `sram_ready`.
  - A following load of 0x00104 hits with `rdata`=0x12345678 and no SRAM read.
- **Write miss, no allocate:** store 0xCAFEF00D to 0x00404 → SRAM write completes; a following load of 0x00404 misses with `sram_r_en`=1.
- **Reset mid-miss:** assert `rst` for one cycle, between clock edges, while in RD_MISS.
  - `sram_r_en`→0 and `ready`→1 immediately, without waiting for a clock edge.
  - Previously cached 0x00104 now misses.
- **Idle and dual enable:**
  - No enables: `ready`=1, `rdata`=0, no SRAM requests for 20 cycles.
  - `MEM_R_EN`=`MEM_W_EN`=1: only `sram_w_en` is asserted.
